// File: rtl/distortion_ctrl.sv
// distortion_ctrl: frame sequencer for the shared distortion datapath; define DIST_CTRL_OVERRUN_CNT_EN for the dropped-frame counter
module distortion_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_WIDTH-1:0] THRESH_RST = 32'h01000000
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  audio_ready,
  input  logic [DATA_WIDTH-1:0] x_l,
  input  logic [DATA_WIDTH-1:0] x_r,
  output logic [DATA_WIDTH-1:0] y_l,
  output logic [DATA_WIDTH-1:0] y_r,
  output logic                  y_valid,
  output logic                  indicator,
  output logic                  busy,
  output logic                  dp_start,
  output logic [DATA_WIDTH-1:0] dp_x,
  input  logic                  dp_done,
  input  logic [DATA_WIDTH-1:0] dp_y,
  output logic [DATA_WIDTH-1:0] threshold,
  input  logic                  cfg_we,
  input  logic [DATA_WIDTH-1:0] cfg_threshold,
  input  logic                  clr_flags,
  output logic                  overrun,
  output logic                  fault,
  output logic [7:0]            overrun_cnt
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, START_L, WAIT_L, START_R, WAIT_R, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] xl_q, xl_d, xr_q, xr_d, rl_q, rl_d, dp_x_q, dp_x_d;
  logic [DATA_WIDTH-1:0] yl_q, yl_d, yr_q, yr_d, thr_q, thr_d, pend_q, pend_d, res;
  logic [CW-1:0] cnt_q, cnt_d;
  logic y_valid_q, y_valid_d, ind_q, ind_d, pend_v_q, pend_v_d;
  logic overrun_q, overrun_d, fault_q, fault_d, idle, drop, waiting, fin;
  assign idle = state_q == IDLE;
  assign drop = audio_ready && !idle;
  assign waiting = state_q == WAIT_L || state_q == WAIT_R;
  assign fin = dp_done || cnt_q == CW'(TIMEOUT);
  assign res = dp_done ? dp_y : state_q == WAIT_L ? xl_q : xr_q;
  always_comb begin
    state_d = state_q;
    xl_d = xl_q;
    xr_d = xr_q;
    rl_d = rl_q;
    cnt_d = cnt_q;
    dp_x_d = dp_x_q;
    yl_d = yl_q;
    yr_d = yr_q;
    y_valid_d = 1'b0;
    ind_d = ind_q;
    case (state_q)
      IDLE: if (audio_ready) begin
        xl_d = x_l;
        xr_d = x_r;
        if (en) begin
          state_d = START_L;
          dp_x_d = x_l;
        end else begin
          yl_d = x_l;
          yr_d = x_r;
          y_valid_d = 1'b1;
          ind_d = 1'b0;
        end
      end
      START_L, START_R: begin
        state_d = state_q == START_L ? WAIT_L : WAIT_R;
        cnt_d = '0;
      end
      WAIT_L, WAIT_R: begin
        cnt_d = cnt_q + CW'(1);
        if (fin && state_q == WAIT_L) begin
          rl_d = res;
          dp_x_d = xr_q;
          state_d = START_R;
        end else if (fin) begin
          yl_d = rl_q;
          yr_d = res;
          y_valid_d = 1'b1;
          ind_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign overrun_d = drop || (overrun_q && !clr_flags);
  assign fault_d = (waiting && fin && !dp_done) || (fault_q && !clr_flags);
  assign thr_d = cfg_we && idle && !audio_ready ? cfg_threshold : pend_v_q && idle ? pend_q : thr_q;
  assign pend_d = cfg_we ? cfg_threshold : pend_q;
  assign pend_v_d = cfg_we ? !(idle && !audio_ready) : pend_v_q && !idle;
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      xl_q <= '0;
      xr_q <= '0;
      rl_q <= '0;
      cnt_q <= '0;
      dp_x_q <= '0;
      yl_q <= '0;
      yr_q <= '0;
      y_valid_q <= 1'b0;
      ind_q <= 1'b0;
      thr_q <= THRESH_RST;
      pend_q <= '0;
      pend_v_q <= 1'b0;
      overrun_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xl_q <= xl_d;
      xr_q <= xr_d;
      rl_q <= rl_d;
      cnt_q <= cnt_d;
      dp_x_q <= dp_x_d;
      yl_q <= yl_d;
      yr_q <= yr_d;
      y_valid_q <= y_valid_d;
      ind_q <= ind_d;
      thr_q <= thr_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      overrun_q <= overrun_d;
      fault_q <= fault_d;
    end
  end
`ifdef DIST_CTRL_OVERRUN_CNT_EN
  logic [7:0] ocnt_q, ocnt_d;
  assign ocnt_d = clr_flags ? {7'b0, drop} : ocnt_q + {7'b0, drop && ocnt_q != 8'hff};
  always_ff @(posedge CLK) ocnt_q <= rst ? 8'h00 : ocnt_d;
  assign overrun_cnt = ocnt_q;
`else
  assign overrun_cnt = 8'h00;
`endif
  assign y_l = yl_q;
  assign y_r = yr_q;
  assign y_valid = y_valid_q;
  assign indicator = ind_q;
  assign busy = !idle;
  assign dp_start = state_q == START_L || state_q == START_R;
  assign dp_x = dp_x_q;
  assign threshold = thr_q;
  assign overrun = overrun_q;
  assign fault = fault_q;
endmodule

// File: tb/tb_distortion_ctrl.sv
// tb_distortion_ctrl: scoreboard bench for distortion_ctrl with a behavioural frame model and a datapath responder
module tb_distortion_ctrl;
  localparam int W = 32;
  localparam int TO = 4;
  localparam logic [W-1:0] TRST = 32'h01000000;
`ifdef DIST_CTRL_OVERRUN_CNT_EN
  localparam logic [7:0] OCNT1 = 8'd1;
`else
  localparam logic [7:0] OCNT1 = 8'd0;
`endif
  logic clk = 0, rst = 1, en = 0, audio_ready = 0, dp_done = 0, cfg_we = 0, clr_flags = 0;
  logic [W-1:0] x_l = 0, x_r = 0, dp_y = 0, cfg_threshold = 0;
  logic [W-1:0] y_l, y_r, dp_x, threshold;
  logic y_valid, indicator, busy, dp_start, overrun, fault;
  logic [7:0] overrun_cnt;
  always #5 clk = ~clk;
  distortion_ctrl #(.DATA_WIDTH(W), .TIMEOUT(TO), .THRESH_RST(TRST)) dut (
    .CLK(clk), .rst(rst), .en(en), .audio_ready(audio_ready), .x_l(x_l), .x_r(x_r),
    .y_l(y_l), .y_r(y_r), .y_valid(y_valid), .indicator(indicator), .busy(busy),
    .dp_start(dp_start), .dp_x(dp_x), .dp_done(dp_done), .dp_y(dp_y),
    .threshold(threshold), .cfg_we(cfg_we), .cfg_threshold(cfg_threshold),
    .clr_flags(clr_flags), .overrun(overrun), .fault(fault), .overrun_cnt(overrun_cnt)
  );
  typedef struct {logic [W-1:0] yl; logic [W-1:0] yr; logic ind; int cyc;} exp_t;
  typedef struct {int lat; logic [W-1:0] x;} dp_t;
  exp_t sb[$];
  dp_t dpq[$];
  int cyc = 0, nvec = 0, nerr = 0, nstart = 0, cd = 0, n0;
  logic exp_fault = 0;
  logic [W-1:0] dpx_hold = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, act, req, cyc);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // datapath stand-in: answers dp_x<<2 after the queued latency; latency 0 never answers
  initial forever begin
    dp_t e;
    tick;
    dp_done = 0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        dp_done = 1;
        dp_y = dpx_hold << 2;
      end
    end
    if (dp_start === 1'b1) begin
      nstart++;
      if (dpq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL dp_start: unexpected request at cycle %0d", cyc);
      end else begin
        e = dpq.pop_front();
        chk("dp_x", dp_x, e.x);
        cd = e.lat;
        dpx_hold = dp_x;
      end
    end
  end
  always @(negedge clk) if (y_valid === 1'b1) begin
    exp_t e;
    if (sb.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL y_valid: unexpected pulse at cycle %0d", cyc);
    end else begin
      e = sb.pop_front();
      chk("y_l", y_l, e.yl);
      chk("y_r", y_r, e.yr);
      chk("indicator", W'(indicator), W'(e.ind));
      chk("y_valid_cycle", cyc, e.cyc);
    end
  end
  // issues a frame in the current cycle and predicts its result and completion cycle
  task automatic frame(input logic e, input logic [W-1:0] xl, input logic [W-1:0] xr,
                       input int ll, input int lr, input bit abort);
    exp_t x;
    int el, er;
    audio_ready = 1;
    en = e;
    x_l = xl;
    x_r = xr;
    if (!e) begin
      x.yl = xl;
      x.yr = xr;
      x.ind = 0;
      x.cyc = cyc + 1;
    end else begin
      el = ll > 0 ? cyc + 1 + ll : cyc + 2 + TO;
      er = el + 1 + (lr > 0 ? lr : 1 + TO);
      x.yl = ll > 0 ? xl << 2 : xl;
      x.yr = lr > 0 ? xr << 2 : xr;
      x.ind = 1;
      x.cyc = er + 1;
      if (!abort && (ll == 0 || lr == 0)) exp_fault = 1;
      dpq.push_back('{ll, xl});
      dpq.push_back('{lr, xr});
    end
    if (!abort) sb.push_back(x);
    tick;
    audio_ready = 0;
    en = 1'($urandom);
    x_l = $urandom;
    x_r = $urandom;
  endtask
  task automatic wait_idle;
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick;
      n++;
    end
    if (busy !== 1'b0) begin
      nvec++;
      nerr++;
      $display("FAIL wait_idle: busy stuck at cycle %0d", cyc);
    end
  endtask
  task automatic check_reset;
    chk("rst y_l", y_l, 0);
    chk("rst y_r", y_r, 0);
    chk("rst y_valid", W'(y_valid), 0);
    chk("rst indicator", W'(indicator), 0);
    chk("rst busy", W'(busy), 0);
    chk("rst dp_start", W'(dp_start), 0);
    chk("rst dp_x", dp_x, 0);
    chk("rst overrun", W'(overrun), 0);
    chk("rst fault", W'(fault), 0);
    chk("rst overrun_cnt", W'(overrun_cnt), 0);
    chk("rst threshold", threshold, TRST);
  endtask
  task automatic clear_flags;
    clr_flags = 1;
    tick;
    clr_flags = 0;
    exp_fault = 0;
  endtask
  initial begin
    int ll, lr, n;
    repeat (3) tick;
    rst = 0;
    check_reset;
    n0 = nstart;
    frame(1, 32'h00000100, 32'h00000200, 1, 1, 0);
    wait_idle;
    chk("t1 dp_starts", nstart - n0, 2);
    n0 = nstart;
    frame(0, 32'h12345678, 32'h9abcdef0, 0, 0, 0);
    wait_idle;
    tick;
    chk("bypass dp_starts", nstart - n0, 0);
    frame(1, 5, 7, 0, 0, 0);
    wait_idle;
    chk("timeout fault", W'(fault), 1);
    clear_flags;
    chk("clr fault", W'(fault), 0);
    frame(1, 32'h00000011, 32'h00000022, 2, 2, 0);
    tick;
    audio_ready = 1;
    tick;
    audio_ready = 0;
    chk("overrun", W'(overrun), 1);
    chk("overrun_cnt", W'(overrun_cnt), W'(OCNT1));
    wait_idle;
    clear_flags;
    chk("clr overrun", W'(overrun), 0);
    chk("clr overrun_cnt", W'(overrun_cnt), 0);
    frame(1, 32'h00000033, 32'h00000044, 5, 5, 0);
    tick;
    cfg_we = 1;
    cfg_threshold = 32'h00800000;
    tick;
    cfg_we = 0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      chk("thr held in frame", threshold, TRST);
      tick;
      n++;
    end
    tick;
    chk("thr applied", threshold, 32'h00800000);
    cfg_we = 1;
    cfg_threshold = 32'h00400000;
    tick;
    cfg_we = 0;
    chk("thr direct", threshold, 32'h00400000);
    cfg_we = 1;
    cfg_threshold = 32'h00300000;
    frame(1, 32'h00000055, 32'h00000066, 1, 1, 0);
    cfg_we = 0;
    chk("thr deferred", threshold, 32'h00400000);
    wait_idle;
    tick;
    chk("thr after frame", threshold, 32'h00300000);
    frame(1, 32'h00000077, 32'h00000088, 1, 0, 1);
    cfg_we = 1;
    cfg_threshold = 32'h00200000;
    tick;
    cfg_we = 0;
    tick;
    chk("in WAIT_R busy", W'(busy), 1);
    rst = 1;
    tick;
    rst = 0;
    check_reset;
    repeat (2) tick;
    chk("pending dropped", threshold, TRST);
    frame(1, 32'h00000099, 32'h000000aa, 1, 1, 0);
    wait_idle;
    repeat (40) begin
      ll = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 5);
      lr = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 5);
      frame(1'($urandom_range(0, 3) != 0), $urandom, $urandom, ll, lr, 0);
      wait_idle;
      repeat ($urandom_range(0, 3)) tick;
    end
    tick;
    chk("fault sticky", W'(fault), W'(exp_fault));
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick;
      n++;
    end
    chk("scoreboard drained", sb.size(), 0);
    chk("dp requests drained", dpq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
